// File: rtl/reorder_buffer_pkg.sv
// Entry type encodings, entry layout and default sizing shared by the reorder buffer and its users.
package reorder_buffer_pkg;

    localparam int ROB_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ROB_TYPE_REG    = 2'd0,
        ROB_TYPE_STORE  = 2'd1,
        ROB_TYPE_BRANCH = 2'd2,
        ROB_TYPE_EXIT   = 2'd3
    } rob_type_e;

    typedef struct packed {
        logic        busy;
        logic        ready;
        rob_type_e   kind;
        logic [4:0]  dest;
        logic [31:0] value;
        logic [31:0] pred_pc;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer: allocates at tail, captures CDB results,
// commits the head in program order and forwards operands by ROB id.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_WIDTH = ROB_WIDTH_DEFAULT
) (
    input  logic                 clockIn,
    input  logic                 resetIn,
    input  logic                 clearIn,
    input  logic                 readyIn,
    input  logic                 robAddValid,
    input  logic [1:0]           robAddType,
    input  logic [4:0]           robAddDest,
    input  logic [31:0]          robAddValue,
    input  logic                 robAddReady,
    input  logic [31:0]          robAddPredPc,
    output logic [ROB_WIDTH-1:0] robTailId,
    output logic                 robFull,
    input  logic                 cdbValid,
    input  logic [ROB_WIDTH-1:0] cdbRobId,
    input  logic [31:0]          cdbValue,
    input  logic [ROB_WIDTH-1:0] robRs1Dep,
    input  logic [ROB_WIDTH-1:0] robRs2Dep,
    output logic                 robRs1Ready,
    output logic                 robRs2Ready,
    output logic [31:0]          robRs1Value,
    output logic [31:0]          robRs2Value,
    output logic                 regUpdateValid,
    output logic [4:0]           regUpdateDest,
    output logic [31:0]          regUpdateValue,
    output logic [ROB_WIDTH-1:0] regUpdateRobId,
    output logic                 storeCommitValid,
    output logic [ROB_WIDTH-1:0] storeCommitRobId,
    output logic                 clearOut,
    output logic [31:0]          newPc,
    output logic                 haltOut
);

    localparam int DEPTH = 1 << ROB_WIDTH;

    rob_entry_t           entries [DEPTH];
    logic [ROB_WIDTH-1:0] head;
    logic [ROB_WIDTH-1:0] tail;
    logic [ROB_WIDTH:0]   count;
    logic                 pending_flush;

    rob_entry_t           head_entry;
    rob_entry_t           new_entry;
    logic                 do_issue;
    logic                 do_commit;
    logic                 mispredict;
    logic                 rs1_hit;
    logic                 rs2_hit;

    assign robFull    = (count == (ROB_WIDTH + 1)'(DEPTH));
    assign robTailId  = tail;
    assign head_entry = entries[head];

    // Issue and commit both freeze while a mispredict flush waits for clearIn.
    assign do_issue   = robAddValid && !robFull && !pending_flush;
    assign do_commit  = (count != '0) && head_entry.busy && head_entry.ready
                        && !pending_flush && !haltOut;
    assign mispredict = (head_entry.value != head_entry.pred_pc);

    // A broadcast in flight this cycle counts as ready so dependents need not wait an edge.
    assign rs1_hit     = cdbValid && (cdbRobId == robRs1Dep);
    assign rs2_hit     = cdbValid && (cdbRobId == robRs2Dep);
    assign robRs1Ready = entries[robRs1Dep].ready || rs1_hit;
    assign robRs2Ready = entries[robRs2Dep].ready || rs2_hit;
    assign robRs1Value = rs1_hit ? cdbValue : entries[robRs1Dep].value;
    assign robRs2Value = rs2_hit ? cdbValue : entries[robRs2Dep].value;

    // NOTE: every field gets a value here, so this block cannot infer a latch.
    always_comb begin
        new_entry         = '0;
        new_entry.busy    = 1'b1;
        new_entry.ready   = robAddReady;
        new_entry.kind    = rob_type_e'(robAddType);
        new_entry.dest    = robAddDest;
        new_entry.value   = robAddValue;
        new_entry.pred_pc = robAddPredPc;
    end

    // NOTE: state uses non-blocking assignments so every read below sees pre-edge values;
    // the issue write is last so it wins over a same-slot writeback or commit.
    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            // NOTE: the entry array is reset too, so forwarded values read as zero after reset.
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            pending_flush    <= 1'b0;
            regUpdateValid   <= 1'b0;
            regUpdateDest    <= '0;
            regUpdateValue   <= '0;
            regUpdateRobId   <= '0;
            storeCommitValid <= 1'b0;
            storeCommitRobId <= '0;
            clearOut         <= 1'b0;
            newPc            <= '0;
            haltOut          <= 1'b0;
        end else if (clearIn) begin
            for (int i = 0; i < DEPTH; i++) entries[i].busy <= 1'b0;
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            pending_flush    <= 1'b0;
            regUpdateValid   <= 1'b0;
            storeCommitValid <= 1'b0;
            clearOut         <= 1'b0;
        end else begin
            regUpdateValid   <= 1'b0;
            storeCommitValid <= 1'b0;
            clearOut         <= 1'b0;
            if (readyIn) begin
                if (cdbValid && entries[cdbRobId].busy) begin
                    entries[cdbRobId].ready <= 1'b1;
                    entries[cdbRobId].value <= cdbValue;
                end
                if (do_commit) begin
                    entries[head].busy <= 1'b0;
                    head               <= head + 1'b1;
                    case (head_entry.kind)
                        ROB_TYPE_REG: begin
                            regUpdateValid <= 1'b1;
                            regUpdateDest  <= head_entry.dest;
                            regUpdateValue <= head_entry.value;
                            regUpdateRobId <= head;
                        end
                        ROB_TYPE_STORE: begin
                            storeCommitValid <= 1'b1;
                            storeCommitRobId <= head;
                        end
                        ROB_TYPE_BRANCH: begin
                            if (mispredict) begin
                                clearOut      <= 1'b1;
                                newPc         <= head_entry.value;
                                pending_flush <= 1'b1;
                            end
                        end
                        ROB_TYPE_EXIT: haltOut <= 1'b1;
                    endcase
                end
                if (do_issue) begin
                    entries[tail] <= new_entry;
                    tail          <= tail + 1'b1;
                end
                count <= count + (ROB_WIDTH + 1)'(do_issue) - (ROB_WIDTH + 1)'(do_commit);
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed-vector bench for reorder_buffer with hand-computed expectations.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    localparam int W = 4;

    logic          clockIn = 1'b0;
    logic          resetIn, clearIn, readyIn;
    logic          robAddValid, robAddReady;
    logic [1:0]    robAddType;
    logic [4:0]    robAddDest;
    logic [31:0]   robAddValue, robAddPredPc;
    logic [W-1:0]  robTailId;
    logic          robFull;
    logic          cdbValid;
    logic [W-1:0]  cdbRobId;
    logic [31:0]   cdbValue;
    logic [W-1:0]  robRs1Dep, robRs2Dep;
    logic          robRs1Ready, robRs2Ready;
    logic [31:0]   robRs1Value, robRs2Value;
    logic          regUpdateValid;
    logic [4:0]    regUpdateDest;
    logic [31:0]   regUpdateValue;
    logic [W-1:0]  regUpdateRobId;
    logic          storeCommitValid;
    logic [W-1:0]  storeCommitRobId;
    logic          clearOut;
    logic [31:0]   newPc;
    logic          haltOut;

    int vectors     = 0;
    int miscompares = 0;

    reorder_buffer #(.ROB_WIDTH(W)) dut (
        .clockIn(clockIn), .resetIn(resetIn), .clearIn(clearIn), .readyIn(readyIn),
        .robAddValid(robAddValid), .robAddType(robAddType), .robAddDest(robAddDest),
        .robAddValue(robAddValue), .robAddReady(robAddReady), .robAddPredPc(robAddPredPc),
        .robTailId(robTailId), .robFull(robFull),
        .cdbValid(cdbValid), .cdbRobId(cdbRobId), .cdbValue(cdbValue),
        .robRs1Dep(robRs1Dep), .robRs2Dep(robRs2Dep),
        .robRs1Ready(robRs1Ready), .robRs2Ready(robRs2Ready),
        .robRs1Value(robRs1Value), .robRs2Value(robRs2Value),
        .regUpdateValid(regUpdateValid), .regUpdateDest(regUpdateDest),
        .regUpdateValue(regUpdateValue), .regUpdateRobId(regUpdateRobId),
        .storeCommitValid(storeCommitValid), .storeCommitRobId(storeCommitRobId),
        .clearOut(clearOut), .newPc(newPc), .haltOut(haltOut)
    );

    always #5 clockIn = ~clockIn;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge, away from it.
    task automatic tick();
        @(posedge clockIn);
        #1;
    endtask

    task automatic issue(input rob_type_e kind, input logic [4:0] dest, input logic [31:0] value,
                         input logic ready, input logic [31:0] pred_pc);
        robAddValid  = 1'b1;
        robAddType   = kind;
        robAddDest   = dest;
        robAddValue  = value;
        robAddReady  = ready;
        robAddPredPc = pred_pc;
        tick();
        robAddValid  = 1'b0;
    endtask

    task automatic pulse_clear();
        clearIn = 1'b1;
        tick();
        clearIn = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetIn = 1'b1; clearIn = 1'b0; readyIn = 1'b1;
        robAddValid = 1'b0; robAddType = '0; robAddDest = '0; robAddValue = '0;
        robAddReady = 1'b0; robAddPredPc = '0;
        cdbValid = 1'b0; cdbRobId = '0; cdbValue = '0;
        robRs1Dep = '0; robRs2Dep = '0;
        tick(); tick();
        resetIn = 1'b0;
        check("reset_tail", robTailId, 0);
        check("reset_full", robFull, 0);
        check("reset_reg_valid", regUpdateValid, 0);
        check("reset_halt", haltOut, 0);
        check("reset_clear", clearOut, 0);

        // Ready REG x5=7 commits two edges after issue.
        issue(ROB_TYPE_REG, 5'd5, 32'd7, 1'b1, 32'd0);
        check("reg_tail_after_issue", robTailId, 1);
        check("reg_no_early_commit", regUpdateValid, 0);
        tick();
        check("reg_valid", regUpdateValid, 1);
        check("reg_dest", regUpdateDest, 5);
        check("reg_value", regUpdateValue, 7);
        check("reg_robid", regUpdateRobId, 0);
        tick();
        check("reg_pulse_end", regUpdateValid, 0);

        // Store and correctly predicted branch.
        issue(ROB_TYPE_STORE, 5'd0, 32'd0, 1'b1, 32'd0);
        tick();
        check("store_valid", storeCommitValid, 1);
        check("store_robid", storeCommitRobId, 1);
        check("store_no_reg", regUpdateValid, 0);
        issue(ROB_TYPE_BRANCH, 5'd0, 32'h40, 1'b1, 32'h40);
        tick();
        check("branch_ok_no_clear", clearOut, 0);
        pulse_clear();
        check("clear_tail", robTailId, 0);

        // Fill all 16 entries with non-ready work.
        for (int i = 0; i < 16; i++) issue(ROB_TYPE_REG, 5'(i), 32'd0, 1'b0, 32'd0);
        check("full_set", robFull, 1);
        check("full_tail_wrap", robTailId, 0);
        issue(ROB_TYPE_REG, 5'd31, 32'd9, 1'b1, 32'd0);
        check("full_17th_ignored_tail", robTailId, 0);
        check("full_17th_ignored_full", robFull, 1);

        // Same-cycle CDB bypass on the query ports.
        robRs1Dep = 4'd2; robRs2Dep = 4'd3;
        cdbValid = 1'b1; cdbRobId = 4'd2; cdbValue = 32'hAB;
        #1;
        check("bypass_rs1_ready", robRs1Ready, 1);
        check("bypass_rs1_value", robRs1Value, 32'hAB);
        check("bypass_rs2_not_ready", robRs2Ready, 0);
        cdbValid = 1'b0;
        #1;
        check("bypass_gone", robRs1Ready, 0);

        cdbValid = 1'b1; cdbRobId = 4'd0; cdbValue = 32'd3;
        tick();
        cdbValid = 1'b0;
        check("full_cdb_edge_still_full", robFull, 1);
        check("full_cdb_edge_no_commit", regUpdateValid, 0);
        tick();
        check("full_commit_valid", regUpdateValid, 1);
        check("full_commit_value", regUpdateValue, 3);
        check("full_commit_robid", regUpdateRobId, 0);
        check("full_drops", robFull, 0);
        pulse_clear();

        // Mispredicted branch with younger ready entries behind it.
        issue(ROB_TYPE_BRANCH, 5'd0, 32'd0, 1'b0, 32'h100);
        issue(ROB_TYPE_REG, 5'd9, 32'h55, 1'b1, 32'd0);
        issue(ROB_TYPE_REG, 5'd10, 32'h66, 1'b1, 32'd0);
        cdbValid = 1'b1; cdbRobId = 4'd0; cdbValue = 32'h200;
        tick();
        cdbValid = 1'b0;
        tick();
        check("mispredict_clear", clearOut, 1);
        check("mispredict_newpc", newPc, 32'h200);
        check("mispredict_no_reg", regUpdateValid, 0);
        issue(ROB_TYPE_REG, 5'd11, 32'h77, 1'b1, 32'd0);
        check("mispredict_clear_pulse", clearOut, 0);
        check("flush_blocks_issue", robTailId, 3);
        tick();
        check("flush_blocks_commit", regUpdateValid, 0);
        pulse_clear();
        check("flush_clear_tail", robTailId, 0);
        check("flush_clear_full", robFull, 0);

        // Back-to-back issue and commit across the id wrap.
        for (int i = 0; i <= 20; i++) begin
            if (i < 20) begin
                check($sformatf("wrap_tail_%0d", i), robTailId, 32'(i % 16));
                robAddValid = 1'b1; robAddType = ROB_TYPE_REG; robAddDest = 5'(i);
                robAddValue = 32'(100 + i); robAddReady = 1'b1;
            end else begin
                robAddValid = 1'b0;
            end
            tick();
            if (i >= 1) begin
                check($sformatf("wrap_valid_%0d", i - 1), regUpdateValid, 1);
                check($sformatf("wrap_robid_%0d", i - 1), regUpdateRobId, 32'((i - 1) % 16));
                check($sformatf("wrap_value_%0d", i - 1), regUpdateValue, 32'(99 + i));
            end
        end
        robAddValid = 1'b0;
        check("wrap_tail_end", robTailId, 4);

        // EXIT halts commit; clearIn leaves haltOut; resetIn wipes everything.
        issue(ROB_TYPE_EXIT, 5'd0, 32'd0, 1'b1, 32'd0);
        tick();
        check("halt_set", haltOut, 1);
        issue(ROB_TYPE_REG, 5'd3, 32'd1, 1'b1, 32'd0);
        tick();
        check("halt_blocks_commit", regUpdateValid, 0);
        pulse_clear();
        check("halt_survives_clear", haltOut, 1);
        for (int i = 0; i < 5; i++) issue(ROB_TYPE_REG, 5'(i), 32'd0, 1'b0, 32'd0);
        check("pre_reset_tail", robTailId, 5);
        resetIn = 1'b1;
        tick();
        resetIn = 1'b0;
        robRs1Dep = 4'd0;
        #1;
        check("post_reset_tail", robTailId, 0);
        check("post_reset_full", robFull, 0);
        check("post_reset_halt", haltOut, 0);
        check("post_reset_newpc", newPc, 0);
        check("post_reset_reg_valid", regUpdateValid, 0);
        check("post_reset_store_valid", storeCommitValid, 0);
        check("post_reset_clear", clearOut, 0);
        check("post_reset_rs1_ready", robRs1Ready, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
